ahblite_decoder_mux: RTL and testbench

AHBLITE_DECODER_MUX -- requirements
Module: ahblite_decoder_mux

---
 rtl/ahblite_decoder_mux.sv | 113 +++++++++++
 tb/tb_ahblite_decoder_mux.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ahblite_decoder_mux.sv
// rtl/ahblite_decoder_mux.sv - AHB-Lite address decoder, response mux and default slave
module ahblite_decoder_mux #(
    parameter int                            NUM_SLAVES = 4,
    parameter int                            ADDR_WIDTH = 32,
    parameter int                            DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [ADDR_WIDTH-1:0]            haddr_i,
    input  logic [1:0]                       htrans_i,
    output logic [DATA_WIDTH-1:0]            hrdata_o,
    output logic                             hready_o,
    output logic                             hresp_o,
    output logic [NUM_SLAVES-1:0]            hsel_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s_i,
    input  logic [NUM_SLAVES-1:0]            hreadyout_s_i,
    input  logic [NUM_SLAVES-1:0]            hresp_s_i,
    output logic [7:0]                       err_cnt_o
);

    localparam int SW = $clog2(NUM_SLAVES + 1);
    // Index one past the last slave stands for the built-in default slave.
    localparam logic [SW-1:0] DEF = SW'(NUM_SLAVES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [SW-1:0]         match_idx;
    logic [SW-1:0]         dsel;
    logic                  dact;
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  addr_active;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_ready;
    logic                  s_resp;

    assign addr_active = (htrans_i == 2'd2) || (htrans_i == 2'd3);

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_idx = DEF;
        hsel_o    = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                ((haddr_i & SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 (SLV_BASE[k*ADDR_WIDTH +: ADDR_WIDTH] & SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                match_idx = SW'(k);
                hsel_o    = '0;
                hsel_o[k] = 1'b1;
            end
        end
    end

    always_comb begin
        s_rdata = '0;
        s_ready = 1'b1;
        s_resp  = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (dsel == SW'(k)) begin
                s_rdata = hrdata_s_i[k*DATA_WIDTH +: DATA_WIDTH];
                s_ready = hreadyout_s_i[k];
                s_resp  = hresp_s_i[k];
            end
        end
    end

    always_comb begin
        if (dsel == DEF) begin
            hrdata_o = '0;
            hready_o = (state != ST_ERR1);
            hresp_o  = (state != ST_IDLE);
        end else begin
            hrdata_o = s_rdata;
            hready_o = s_ready;
            hresp_o  = s_resp;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_ERR1) begin
            state_nxt = ST_ERR2;
        end else if (hready_o) begin
            state_nxt = ((match_idx == DEF) && addr_active) ? ST_ERR1 : ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dsel      <= DEF;
            dact      <= 1'b0;
            state     <= ST_IDLE;
            err_cnt_o <= 8'd0;
        end else begin
            state <= state_nxt;
            if (hready_o) begin
                dsel <= match_idx;
                dact <= addr_active;
            end
            if ((state == ST_ERR1) && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

    logic unused_dact;
    assign unused_dact = dact;

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// tb/tb_ahblite_decoder_mux.sv - directed bench for ahblite_decoder_mux
module tb_ahblite_decoder_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [1:0]  hsel;
    logic [63:0] hrdata_s;
    logic [1:0]  hreadyout_s;
    logic [1:0]  hresp_s;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    ahblite_decoder_mux #(
        .NUM_SLAVES(2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .SLV_BASE({32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK({32'hFFFF_0000, 32'hFFFF_0000})
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .haddr_i      (haddr),
        .htrans_i     (htrans),
        .hrdata_o     (hrdata),
        .hready_o     (hready),
        .hresp_o      (hresp),
        .hsel_o       (hsel),
        .hrdata_s_i   (hrdata_s),
        .hreadyout_s_i(hreadyout_s),
        .hresp_s_i    (hresp_s),
        .err_cnt_o    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        haddr       = 32'h0;
        htrans      = 2'd0;
        hrdata_s    = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        hreadyout_s = 2'b11;
        hresp_s     = 2'b00;
        step();
        check("rst_hready", {31'd0, hready}, 32'd1);
        check("rst_hresp", {31'd0, hresp}, 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // read from slave 0, no wait
        haddr = 32'h0000_0010; htrans = 2'd2; #1;
        check("s0_hsel", {30'd0, hsel}, 32'd1);
        step();
        haddr = 32'h0; htrans = 2'd0; #1;
        check("s0_hrdata", hrdata, 32'hDEAD_BEEF);
        check("s0_hready", {31'd0, hready}, 32'd1);
        check("s0_hresp", {31'd0, hresp}, 32'd0);

        // slave 1 with three wait states
        haddr = 32'h1000_0004; htrans = 2'd2; #1;
        check("s1_hsel", {30'd0, hsel}, 32'd2);
        step();
        haddr = 32'h0; htrans = 2'd0; hreadyout_s = 2'b01; #1;
        for (int i = 0; i < 3; i++) begin
            check("s1_wait", {31'd0, hready}, 32'd0);
            step();
        end
        hreadyout_s = 2'b11; #1;
        check("s1_done", {31'd0, hready}, 32'd1);
        check("s1_hrdata", hrdata, 32'hCAFE_F00D);
        step();

        // unmapped NONSEQ, master goes IDLE during ERR1
        haddr = 32'h2000_0000; htrans = 2'd2; #1;
        check("unm_hsel", {30'd0, hsel}, 32'd0);
        step();
        htrans = 2'd0; #1;
        check("err1_hready", {31'd0, hready}, 32'd0);
        check("err1_hresp", {31'd0, hresp}, 32'd1);
        check("err1_hrdata", hrdata, 32'h0);
        step();
        check("err2_hready", {31'd0, hready}, 32'd1);
        check("err2_hresp", {31'd0, hresp}, 32'd1);
        check("err2_cnt", {24'd0, err_cnt}, 32'd1);
        step();
        check("post_err_hready", {31'd0, hready}, 32'd1);
        check("post_err_hresp", {31'd0, hresp}, 32'd0);

        // unmapped IDLE: zero-wait OKAY, counter unchanged
        step();
        check("idle_unm_hready", {31'd0, hready}, 32'd1);
        check("idle_unm_hresp", {31'd0, hresp}, 32'd0);
        check("idle_unm_cnt", {24'd0, err_cnt}, 32'd1);

        // 260 back-to-back unmapped NONSEQ transfers
        htrans = 2'd2;
        for (int i = 0; i < 200; i++) step();
        check("b2b_cnt_mid", {24'd0, err_cnt}, 32'd101);
        check("b2b_hresp_mid", {31'd0, hresp}, 32'd1);
        for (int i = 0; i < 320; i++) step();
        check("b2b_cnt_sat", {24'd0, err_cnt}, 32'd255);
        htrans = 2'd0;
        step();
        check("b2b_end_hresp", {31'd0, hresp}, 32'd0);
        check("b2b_end_cnt", {24'd0, err_cnt}, 32'd255);

        // async reset during ERR1
        htrans = 2'd2;
        step();
        check("pre_rst_err1", {31'd0, hready}, 32'd0);
        #2 rst_n = 1'b0; #1;
        check("arst_hready", {31'd0, hready}, 32'd1);
        check("arst_hresp", {31'd0, hresp}, 32'd0);
        check("arst_cnt", {24'd0, err_cnt}, 32'd0);
        htrans = 2'd0;
        step();
        rst_n = 1'b1;
        step();
        check("after_rst_hready", {31'd0, hready}, 32'd1);
        check("after_rst_hresp", {31'd0, hresp}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
